// File: rtl/series_acc.sv
`default_nettype none
// ============================================================================
// Module   : series_acc
// Purpose  : Sums an arithmetic series and captures two running partial sums.
// Revision : 1.0  initial release
// ============================================================================
module series_acc #(
  parameter int W     = 8,
  parameter int N_MAX = 20,
  localparam int CW   = $clog2(N_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  first,
  input  logic [W-1:0]  step,
  input  logic [CW-1:0] n_a,
  input  logic [CW-1:0] n_b,
  input  logic          sat_en,
  output logic [W-1:0]  port_A,
  output logic [W-1:0]  port_B,
  output logic          busy,
  output logic          done,
  output logic          ovf
);

  localparam logic [1:0]    c_st_idle = 2'd0;
  localparam logic [1:0]    c_st_run  = 2'd1;
  localparam logic [1:0]    c_st_done = 2'd2;
  localparam logic [CW-1:0] c_nmax    = CW'(N_MAX);

  logic [1:0]    r_state;
  logic [W-1:0]  r_sum;
  logic [W-1:0]  r_term;
  logic [W-1:0]  r_step;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_na;
  logic [CW-1:0] r_nb;
  logic [CW-1:0] r_nmax;
  logic          r_sat;
  logic          r_ovf;
  logic [W-1:0]  r_port_a;
  logic [W-1:0]  r_port_b;

  logic [CW-1:0] w_na_clamp;
  logic [CW-1:0] w_nb_clamp;
  logic [CW-1:0] w_nmax;
  logic [W:0]    w_sum_ext;
  logic [W-1:0]  w_sum_next;
  logic [CW-1:0] w_count_next;

  assign w_na_clamp = (n_a > c_nmax) ? c_nmax : n_a;
  assign w_nb_clamp = (n_b > c_nmax) ? c_nmax : n_b;
  assign w_nmax     = (w_na_clamp > w_nb_clamp) ? w_na_clamp : w_nb_clamp;

  // Extra bit catches the carry; a saturated sum stays at all-ones because
  // any further non-zero term carries again.
  assign w_sum_ext    = {1'b0, r_sum} + {1'b0, r_term};
  assign w_sum_next   = (w_sum_ext[W] && r_sat) ? {W{1'b1}} : w_sum_ext[W-1:0];
  assign w_count_next = r_count + CW'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= c_st_idle;
      r_sum    <= '0;
      r_term   <= '0;
      r_step   <= '0;
      r_count  <= '0;
      r_na     <= '0;
      r_nb     <= '0;
      r_nmax   <= '0;
      r_sat    <= 1'b0;
      r_ovf    <= 1'b0;
      r_port_a <= '0;
      r_port_b <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (start) begin
            r_step  <= step;
            r_na    <= w_na_clamp;
            r_nb    <= w_nb_clamp;
            r_nmax  <= w_nmax;
            r_sat   <= sat_en;
            r_sum   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_term  <= first;
            if (w_na_clamp == '0) r_port_a <= '0;
            if (w_nb_clamp == '0) r_port_b <= '0;
            r_state <= (w_nmax == '0) ? c_st_done : c_st_run;
          end
        end
        c_st_run: begin
          r_sum   <= w_sum_next;
          r_term  <= r_term + r_step;
          r_count <= w_count_next;
          if (w_sum_ext[W]) r_ovf <= 1'b1;
          // count_next starts at 1, so a zero target never matches here
          if (w_count_next == r_na) r_port_a <= w_sum_next;
          if (w_count_next == r_nb) r_port_b <= w_sum_next;
          if (w_count_next == r_nmax) r_state <= c_st_done;
        end
        c_st_done: r_state <= c_st_idle;
        default:   r_state <= c_st_idle;
      endcase
    end
  end

  assign port_A = r_port_a;
  assign port_B = r_port_b;
  assign busy   = (r_state == c_st_run);
  assign done   = (r_state == c_st_done);
  assign ovf    = r_ovf;

endmodule
`default_nettype wire
